// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, control bundle
// and the helper that builds the unstalled-RUN control pattern.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_AW_DEF  = 5;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned ZERO_REG    = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
        logic dmem_req;
    } ctrl_t;

    localparam ctrl_t CTRL_FROZEN = '{
        pc_write:    1'b0,
        ifid_write:  1'b0,
        ifid_flush:  1'b0,
        idex_bubble: 1'b0,
        pipe_freeze: 1'b1,
        dmem_req:    1'b0
    };

    // Load-use wins over a taken branch; the branch simply re-resolves next cycle.
    function automatic ctrl_t run_ctrl(input logic load_use, input logic branch,
                                       input logic req);
        ctrl_t c;
        c.pc_write    = !load_use;
        c.ifid_write  = !load_use;
        c.ifid_flush  = !load_use && branch;
        c.idex_bubble = load_use;
        c.pipe_freeze = 1'b0;
        c.dmem_req    = req;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);
    logic              start_i;
    logic [REG_AW-1:0] IdRsAddr_i;
    logic [REG_AW-1:0] IdRtAddr_i;
    logic              IdExMemRead_i;
    logic [REG_AW-1:0] IdExRtAddr_i;
    logic              IdBranchTaken_i;
    logic              ExMemMemAccess_i;
    logic              DMemAck_i;

    logic              PcWrite_o;
    logic              IfIdWrite_o;
    logic              IfIdFlush_o;
    logic              IdExBubble_o;
    logic              PipeFreeze_o;
    logic              DMemReq_o;
    logic              MemTimeout_o;
    logic [CNT_W-1:0]  StallCycles_o;

    modport master (
        output start_i, IdRsAddr_i, IdRtAddr_i, IdExMemRead_i, IdExRtAddr_i,
               IdBranchTaken_i, ExMemMemAccess_i, DMemAck_i,
        input  PcWrite_o, IfIdWrite_o, IfIdFlush_o, IdExBubble_o, PipeFreeze_o,
               DMemReq_o, MemTimeout_o, StallCycles_o
    );

    modport slave (
        input  start_i, IdRsAddr_i, IdRtAddr_i, IdExMemRead_i, IdExRtAddr_i,
               IdBranchTaken_i, ExMemMemAccess_i, DMemAck_i,
        output PcWrite_o, IfIdWrite_o, IfIdFlush_o, IdExBubble_o, PipeFreeze_o,
               DMemReq_o, MemTimeout_o, StallCycles_o
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Load-use comparator: a load in EX whose destination is read by the instruction in ID.
module pipeline_hazard_ctrl_hazard_cmp
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              mem_read_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    output logic              hazard_c_o
);
    logic dst_live_c;

    // r0 is hardwired, so a load targeting it can never feed a consumer.
    assign dst_live_c = mem_read_i && (ex_rt_i != REG_AW'(ZERO_REG));
    assign hazard_c_o = dst_live_c && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory freeze with timeout, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned       WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST  = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
    localparam bit                TIMEOUT_EN = (TIMEOUT != 0);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              timeout_q, timeout_d;

    logic  load_use_c;
    logic  mem_stall_c;
    logic  busy_c;
    ctrl_t ctrl_c;

    pipeline_hazard_ctrl_hazard_cmp #(
        .REG_AW (REG_AW)
    ) u_hazard_cmp (
        .mem_read_i (bus.IdExMemRead_i),
        .ex_rt_i    (bus.IdExRtAddr_i),
        .id_rs_i    (bus.IdRsAddr_i),
        .id_rt_i    (bus.IdRtAddr_i),
        .hazard_c_o (load_use_c)
    );

    assign mem_stall_c = bus.ExMemMemAccess_i && !bus.DMemAck_i;

    // Next-state and Mealy control outputs.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        stall_d   = stall_q;
        timeout_d = timeout_q;
        ctrl_c    = CTRL_FROZEN;
        busy_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                busy_c = 1'b1;
                if (mem_stall_c) begin
                    ctrl_c.dmem_req = 1'b1;
                    wait_d          = '0;
                    state_d         = ST_MEM_WAIT;
                end else begin
                    ctrl_c = run_ctrl(load_use_c, bus.IdBranchTaken_i, bus.ExMemMemAccess_i);
                    if (!bus.start_i) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_MEM_WAIT: begin
                busy_c          = 1'b1;
                ctrl_c.dmem_req = 1'b1;
                if (bus.DMemAck_i) begin
                    // The ack cycle already behaves as a normal RUN cycle.
                    ctrl_c  = run_ctrl(load_use_c, bus.IdBranchTaken_i, 1'b1);
                    wait_d  = '0;
                    state_d = ST_RUN;
                end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_HALT: begin
                ctrl_c = CTRL_FROZEN;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (busy_c && !ctrl_c.pc_write && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.PcWrite_o     = ctrl_c.pc_write;
    assign bus.IfIdWrite_o   = ctrl_c.ifid_write;
    assign bus.IfIdFlush_o   = ctrl_c.ifid_flush;
    assign bus.IdExBubble_o  = ctrl_c.idex_bubble;
    assign bus.PipeFreeze_o  = ctrl_c.pipe_freeze;
    assign bus.DMemReq_o     = ctrl_c.dmem_req;
    assign bus.MemTimeout_o  = timeout_q;
    assign bus.StallCycles_o = stall_q;

endmodule
